// File: rtl/agc_iq_pacer.sv
// agc_iq_pacer: FIFO-buffered multi-channel I/Q frame source, one channel per paced tick,
// with AGC config shadowed to frame starts. Define AGC_PACER_STATS_EN for statistics outputs.
module agc_iq_pacer #(
  parameter int W_IN        = 16,
  parameter int FILTERWIDTH = 13,
  parameter int RWIDTH      = 8,
  parameter int N_CH        = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int PERIOD_W    = 8,
  localparam int CHW        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*W_IN-1:0]   s_chans_dataI,
  input  logic [N_CH*W_IN-1:0]   s_chans_dataQ,
  input  logic                   s_chans_valid,
  output logic                   s_chans_ready,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [FILTERWIDTH-1:0] cfg_filter,
  input  logic [FILTERWIDTH-1:0] cfg_error,
  input  logic [RWIDTH-1:0]      cfg_r,
  input  logic                   cfg_update,
  output logic [W_IN-1:0]        m_dataI,
  output logic [W_IN-1:0]        m_dataQ,
  output logic [CHW-1:0]         m_chan,
  output logic                   m_valid,
  output logic [FILTERWIDTH-1:0] Filter_Coefficient,
  output logic [FILTERWIDTH-1:0] Error_Coefficient,
  output logic [RWIDTH-1:0]      R_level,
  output logic [LW-1:0]          fifo_level,
`ifdef AGC_PACER_STATS_EN
  output logic [31:0]            stat_frames,
  output logic [15:0]            stat_underruns,
`endif
  output logic                   underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = N_CH * W_IN;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [PERIOD_W-1:0] tcnt;
  logic [PERIOD_W-1:0] last_idx;
  logic                tick;

  // period 0 behaves like period 1; a counter beyond a shrunken period restarts at 0
  always_comb begin
    last_idx = (period == '0) ? '0 : period - PERIOD_W'(1);
    tick     = (tcnt == last_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tcnt <= '0;
    else if (tcnt >= last_idx) tcnt <= '0;
    else                       tcnt <= tcnt + PERIOD_W'(1);
  end

  logic [FW-1:0] mem_i [FIFO_DEPTH];
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          under_evt;

  always_comb begin
    full          = (fifo_level == LW'(FIFO_DEPTH));
    empty         = (fifo_level == '0);
    s_chans_ready = !full;
    push          = s_chans_valid && !full;
    pop           = tick && (state == IDLE) && !empty;
    under_evt     = 1'b0;
    under_evt     = tick && (state == IDLE) && empty;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr] <= s_chans_dataI;
      mem_q[wr_ptr] <= s_chans_dataQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  logic [FW-1:0]          cur_i;
  logic [FW-1:0]          cur_q;
  logic [CHW-1:0]         ch;
  logic                   emitted;
  logic                   pend;
  logic [FILTERWIDTH-1:0] pend_filter;
  logic [FILTERWIDTH-1:0] pend_error;
  logic [RWIDTH-1:0]      pend_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cur_i              <= '0;
      cur_q              <= '0;
      ch                 <= '0;
      emitted            <= 1'b0;
      pend               <= 1'b0;
      pend_filter        <= '0;
      pend_error         <= '0;
      pend_r             <= '0;
      m_dataI            <= '0;
      m_dataQ            <= '0;
      m_chan             <= '0;
      m_valid            <= 1'b0;
      Filter_Coefficient <= '0;
      Error_Coefficient  <= '0;
      R_level            <= '0;
      underrun           <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      // an update landing on a frame start stays pending for the following frame
      if (cfg_update) begin
        pend        <= 1'b1;
        pend_filter <= cfg_filter;
        pend_error  <= cfg_error;
        pend_r      <= cfg_r;
      end else if (pop) begin
        pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            cur_i   <= mem_i[rd_ptr];
            cur_q   <= mem_q[rd_ptr];
            m_dataI <= mem_i[rd_ptr][W_IN-1:0];
            m_dataQ <= mem_q[rd_ptr][W_IN-1:0];
            m_chan  <= '0;
            m_valid <= 1'b1;
            emitted <= 1'b1;
            ch      <= CHW'(1);
            if (pend) begin
              Filter_Coefficient <= pend_filter;
              Error_Coefficient  <= pend_error;
              R_level            <= pend_r;
            end
            if (N_CH > 1) state <= RUN;
          end else if (under_evt && emitted) begin
            underrun <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            m_dataI <= cur_i[ch*W_IN +: W_IN];
            m_dataQ <= cur_q[ch*W_IN +: W_IN];
            m_chan  <= ch;
            m_valid <= 1'b1;
            if (ch == CHW'(N_CH - 1)) state <= IDLE;
            else                      ch    <= ch + CHW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AGC_PACER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames    <= '0;
      stat_underruns <= '0;
    end else begin
      if (pop) stat_frames <= stat_frames + 32'd1;
      if (under_evt && emitted && (stat_underruns != 16'hFFFF))
        stat_underruns <= stat_underruns + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_agc_iq_pacer.sv
// Self-checking bench for agc_iq_pacer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_agc_iq_pacer;
  localparam int W_IN        = 16;
  localparam int FILTERWIDTH = 13;
  localparam int RWIDTH      = 8;
  localparam int N_CH        = 2;
  localparam int FIFO_DEPTH  = 16;
  localparam int PERIOD_W    = 8;
  localparam int CHW         = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;
  localparam int FW          = N_CH * W_IN;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [FW-1:0]          s_chans_dataI = '0;
  logic [FW-1:0]          s_chans_dataQ = '0;
  logic                   s_chans_valid = 1'b0;
  logic                   s_chans_ready;
  logic [PERIOD_W-1:0]    period = 8'd1;
  logic [FILTERWIDTH-1:0] cfg_filter = '0;
  logic [FILTERWIDTH-1:0] cfg_error = '0;
  logic [RWIDTH-1:0]      cfg_r = '0;
  logic                   cfg_update = 1'b0;
  logic [W_IN-1:0]        m_dataI;
  logic [W_IN-1:0]        m_dataQ;
  logic [CHW-1:0]         m_chan;
  logic                   m_valid;
  logic [FILTERWIDTH-1:0] Filter_Coefficient;
  logic [FILTERWIDTH-1:0] Error_Coefficient;
  logic [RWIDTH-1:0]      R_level;
  logic [LW-1:0]          fifo_level;
  logic                   underrun;
`ifdef AGC_PACER_STATS_EN
  logic [31:0]            stat_frames;
  logic [15:0]            stat_underruns;
`endif

  agc_iq_pacer #(
    .W_IN(W_IN), .FILTERWIDTH(FILTERWIDTH), .RWIDTH(RWIDTH),
    .N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_chans_dataI(s_chans_dataI), .s_chans_dataQ(s_chans_dataQ),
    .s_chans_valid(s_chans_valid), .s_chans_ready(s_chans_ready),
    .period(period),
    .cfg_filter(cfg_filter), .cfg_error(cfg_error), .cfg_r(cfg_r), .cfg_update(cfg_update),
    .m_dataI(m_dataI), .m_dataQ(m_dataQ), .m_chan(m_chan), .m_valid(m_valid),
    .Filter_Coefficient(Filter_Coefficient), .Error_Coefficient(Error_Coefficient),
    .R_level(R_level), .fifo_level(fifo_level),
`ifdef AGC_PACER_STATS_EN
    .stat_frames(stat_frames), .stat_underruns(stat_underruns),
`endif
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [FW-1:0]          mq_i[$];
  logic [FW-1:0]          mq_q[$];
  logic [FW-1:0]          cur_i, cur_q;
  int                     tcnt, pos, eff;
  bit                     emitted, pend, tick, start, can_push;
  logic [FILTERWIDTH-1:0] p_f, p_e, e_f, e_e;
  logic [RWIDTH-1:0]      p_r, e_r;
  logic                   e_valid, e_under;
  logic [W_IN-1:0]        e_i, e_q;
  int                     e_chan;
  logic [31:0]            e_frames;
  int                     e_unders;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_i.delete(); mq_q.delete();
      tcnt = 0; pos = 0; emitted = 0; pend = 0;
      cur_i = '0; cur_q = '0;
      p_f = '0; p_e = '0; p_r = '0; e_f = '0; e_e = '0; e_r = '0;
      e_valid = 0; e_under = 0; e_i = '0; e_q = '0; e_chan = 0;
      e_frames = '0; e_unders = 0;
    end else begin
      eff      = (period == 0) ? 1 : int'(period);
      tick     = (tcnt == eff - 1);
      tcnt     = (tcnt >= eff - 1) ? 0 : tcnt + 1;
      can_push = s_chans_valid && (mq_i.size() < FIFO_DEPTH);
      start    = 0;
      e_valid  = 0;
      if (tick) begin
        if (pos == 0) begin
          if (mq_i.size() > 0) begin
            cur_i = mq_i.pop_front();
            cur_q = mq_q.pop_front();
            start = 1; emitted = 1; e_frames = e_frames + 1;
            if (pend) begin e_f = p_f; e_e = p_e; e_r = p_r; end
          end else if (emitted) begin
            e_under = 1;
            if (e_unders < 16'hFFFF) e_unders++;
          end
        end
        if (start || pos != 0) begin
          e_valid = 1;
          e_i = cur_i[pos*W_IN +: W_IN];
          e_q = cur_q[pos*W_IN +: W_IN];
          e_chan = pos;
          pos = (pos + 1) % N_CH;
        end
      end
      if (cfg_update) begin
        pend = 1; p_f = cfg_filter; p_e = cfg_error; p_r = cfg_r;
      end else if (start) begin
        pend = 0;
      end
      if (can_push) begin
        mq_i.push_back(s_chans_dataI);
        mq_q.push_back(s_chans_dataQ);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", m_valid, e_valid);
      check("m_dataI", m_dataI, e_i);
      check("m_dataQ", m_dataQ, e_q);
      check("m_chan", m_chan, 32'(e_chan));
      check("filter", Filter_Coefficient, e_f);
      check("error", Error_Coefficient, e_e);
      check("r_level", R_level, e_r);
      check("fifo_level", fifo_level, 32'(mq_i.size()));
      check("ready", s_chans_ready, 32'(mq_i.size() < FIFO_DEPTH));
      check("underrun", underrun, e_under);
`ifdef AGC_PACER_STATS_EN
      check("stat_frames", stat_frames, e_frames);
      check("stat_underruns", stat_underruns, 32'(e_unders));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [FW-1:0] pk2(input int a, input int b);
    return {W_IN'(b), W_IN'(a)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    s_chans_valid = 1'b0;
    cfg_update = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [FW-1:0] di, input logic [FW-1:0] dq);
    s_chans_dataI = di;
    s_chans_dataQ = dq;
    s_chans_valid = 1'b1;
    @(negedge clk);
    s_chans_valid = 1'b0;
  endtask

  task automatic cfg(input int f, input int e, input int r);
    cfg_filter = FILTERWIDTH'(f);
    cfg_error = FILTERWIDTH'(e);
    cfg_r = RWIDTH'(r);
    cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_valid !== 1'b1 && k < budget);
    if (m_valid !== 1'b1) check({nm, " timeout"}, m_valid, 32'd1);
  endtask

  initial begin
    int c0, c1, cnt;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst m_valid", m_valid, 0);
    check("rst fifo_level", fifo_level, 0);
    check("rst ready", s_chans_ready, 1);
    check("rst underrun", underrun, 0);
    rst_n = 1'b1;

    // 1: paced two-channel frame
    period = 8'd40;
    do_reset();
    push(pk2(-5, 7), pk2(3, -1));
    wait_pulse(60, "t1 ch0");
    c0 = cyc;
    check("t1 ch0 I", m_dataI, 32'h0000FFFB);
    check("t1 ch0 Q", m_dataQ, 32'd3);
    check("t1 ch0 chan", m_chan, 0);
    wait_pulse(60, "t1 ch1");
    c1 = cyc;
    check("t1 ch1 I", m_dataI, 32'd7);
    check("t1 ch1 Q", m_dataQ, 32'h0000FFFF);
    check("t1 ch1 chan", m_chan, 1);
    check("t1 spacing", c1 - c0, 40);

    // 2: fill to full, then drain back-to-back at period 1
    period = 8'd255;
    do_reset();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      s_chans_dataI = $urandom;
      s_chans_dataQ = $urandom;
      s_chans_valid = 1'b1;
      @(negedge clk);
    end
    s_chans_valid = 1'b0;
    check("t2 level full", fifo_level, FIFO_DEPTH);
    check("t2 ready full", s_chans_ready, 0);
    period = 8'd1;
    wait_pulse(10, "t2 first");
    cnt = 0;
    for (int i = 0; i < 2 * FIFO_DEPTH - 1; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) cnt++;
    end
    check("t2 pulses", cnt, 2 * FIFO_DEPTH - 1);
    check("t2 level empty", fifo_level, 0);
    check("t2 underrun", underrun, 0);
    period = 8'd255;

    // 3: config update between channels waits for next frame
    period = 8'd10;
    do_reset();
    cfg(13'h123, 13'h0AB, 50);
    push(pk2(1, 2), pk2(3, 4));
    push(pk2(5, 6), pk2(7, 8));
    wait_pulse(40, "t3 a0");
    check("t3 a0 R", R_level, 50);
    check("t3 a0 filter", Filter_Coefficient, 32'h123);
    cfg(13'h0F0, 13'h00F, 100);
    wait_pulse(40, "t3 a1");
    check("t3 a1 chan", m_chan, 1);
    check("t3 a1 R", R_level, 50);
    wait_pulse(40, "t3 b0");
    check("t3 b0 chan", m_chan, 0);
    check("t3 b0 R", R_level, 100);
    check("t3 b0 filter", Filter_Coefficient, 32'h0F0);

    // 4: underrun at the first empty boundary tick, sticky afterwards
    period = 8'd4;
    do_reset();
    push(pk2(9, 10), pk2(11, 12));
    wait_pulse(20, "t4 ch0");
    wait_pulse(20, "t4 ch1");
    check("t4 no underrun yet", underrun, 0);
    repeat (3) @(negedge clk);
    check("t4 before tick", underrun, 0);
    @(negedge clk);
    check("t4 at tick", underrun, 1);
    repeat (20) @(negedge clk);
    check("t4 sticky", underrun, 1);

    // 5: asynchronous reset mid-frame
    period = 8'd5;
    do_reset();
    push(pk2(100, -200), pk2(-300, 400));
    push(pk2(1, 1), pk2(1, 1));
    wait_pulse(20, "t5 ch0");
    check("t5 ch0 I", m_dataI, 32'd100);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5 rst I", m_dataI, 0);
    check("t5 rst Q", m_dataQ, 0);
    check("t5 rst level", fifo_level, 0);
    check("t5 rst R", R_level, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) cnt++;
    end
    check("t5 no pulse", cnt, 0);
    check("t5 underrun", underrun, 0);

`ifdef AGC_PACER_STATS_EN
    // 6: statistics
    period = 8'd255;
    do_reset();
    push(pk2(1, 2), pk2(3, 4));
    push(pk2(5, 6), pk2(7, 8));
    push(pk2(9, 10), pk2(11, 12));
    period = 8'd3;
    for (int i = 0; i < 3 * N_CH; i++) wait_pulse(20, "t6 pulse");
    repeat (6) @(negedge clk);
    check("t6 frames", stat_frames, 3);
    check("t6 underruns", stat_underruns, 2);
`endif

    // randomized traffic
    period = 8'd2;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      s_chans_valid = ($urandom_range(0, 99) < 40);
      s_chans_dataI = FW'($urandom);
      s_chans_dataQ = FW'($urandom);
      cfg_update = ($urandom_range(0, 29) == 0);
      cfg_filter = FILTERWIDTH'($urandom);
      cfg_error = FILTERWIDTH'($urandom);
      cfg_r = RWIDTH'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 5))
          0: period = 8'd0;
          1: period = 8'd1;
          2: period = 8'd2;
          3: period = 8'd3;
          4: period = 8'd6;
          default: period = 8'd9;
        endcase
      end
      @(negedge clk);
    end
    s_chans_valid = 1'b0;
    cfg_update = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
